// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch front end: the fetch FSM state encoding and
// the top-nibble opcode constants. The PC register and decode stages import
// the same package, so the encodings must stay in step with them.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    // Fetch FSM states. The encoding is fixed because it is shared with
    // debug visibility in the neighbouring stages.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // latch the PC, start a request next cycle
        FETCH   = 2'd1,   // request outstanding, waiting for mem_ack
        DELIVER = 2'd2,   // instruction presented to decode
        HALTED  = 2'd3    // HLT delivered, fetch frozen until reset
    } fetch_state_e;

    // Opcode field lives in instruction[15:12].
    localparam logic [3:0] OPCODE_B   = 4'hC;
    localparam logic [3:0] OPCODE_BR  = 4'hD;
    localparam logic [3:0] OPCODE_HLT = 4'hF;

    // Extract the opcode nibble of a 16-bit instruction word.
    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Takes the PC from the PC register, issues one read to a variable-latency
// instruction memory, and hands the returned word to decode. fetch_stall
// holds the PC register everywhere except the cycle in which decode accepts
// a delivered instruction, so the PC advances exactly once per instruction.
// A taken-branch flush discards in-flight or held data; delivering HLT
// freezes the block until reset. No prefetch: one instruction per N+2 cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   pc           current PC from the PC register
//   flush        one-cycle redirect pulse from a taken branch
//   stall_in     decode cannot accept this cycle
//   mem_req      read request, held until mem_ack
//   mem_addr     read address, stable while mem_req is high
//   mem_ack      one-cycle pulse, mem_rdata valid in that cycle
//   mem_rdata    instruction word from memory
//   instruction  instruction presented to decode
//   instr_valid  instruction is valid this cycle
//   fetch_stall  PC register must hold
//   halted       HLT delivered, fetch frozen
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter int         DATA_W     = 16,
    parameter logic [3:0] HLT_OPCODE = OPCODE_HLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              stall_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              fetch_stall,
    output logic              halted
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] instr_q;
    logic              drop_q;    // a flush hit the outstanding request
    logic [3:0]        opcode;

    assign opcode = instr_q[DATA_W-1 -: 4];

    // Single-process FSM. mem_ack outside FETCH falls through untouched,
    // which is how stray acknowledges are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q <= pc;
                    // A redirect arriving now means pc is about to change;
                    // stay here and relatch next cycle.
                    if (!flush) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        // The memory cannot abort a read, so a flushed
                        // request is completed and its data thrown away.
                        if (drop_q || flush) begin
                            drop_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            instr_q <= mem_rdata;
                            state_q <= DELIVER;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                DELIVER: begin
                    // Flush beats HLT: a halt on a squashed path never halts.
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (!stall_in) begin
                        state_q <= (opcode == HLT_OPCODE) ? HALTED : IDLE;
                    end
                end
                HALTED: begin
                    // Only reset leaves this state.
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only; mem_rdata never
    // reaches decode combinationally.
    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = addr_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == DELIVER);
    assign halted      = (state_q == HALTED);

    // The PC may only move in the cycle decode takes the instruction. A
    // flush in that cycle releases the stall so the redirect target loads.
    assign fetch_stall = (state_q == DELIVER) ? (stall_in & ~flush) : 1'b1;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Scoreboard bench. Stimulus pushes each expected delivered instruction (and
// the expected spacing from the previous delivery) into a queue; an
// independent monitor pops an entry whenever a delivery ends (accepted or
// flushed) and compares. A small PC-register model advances pc by 2 when
// fetch_stall is low, and imem_model answers requests after mem_lat cycles.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        flush;
    logic        stall_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        fetch_stall;
    logic        halted;

    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        force_ack;
    logic        model_ack;
    int          mem_lat;
    int          mem_cnt;
    logic [15:0] mem [0:65535];

    int n_checks;
    int n_fail;

    typedef struct {
        logic [15:0] data;
        int          gap;   // cycles since previous delivery end, 0 = unchecked
    } exp_t;
    exp_t exp_q[$];

    instruction_fetch #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .flush      (flush),
        .stall_in   (stall_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .fetch_stall(fetch_stall),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register model: load on redirect, otherwise step by 2 when released.
    always @(posedge clk) begin
        if (!rst_n)            pc <= 16'h0000;
        else if (pc_load)      pc <= pc_load_val;
        else if (!fetch_stall) pc <= pc + 16'h0002;
    end

    // imem_model: answers a held request after mem_lat cycles, on the
    // falling edge so the DUT samples a settled ack.
    assign mem_ack = model_ack | force_ack;
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_cnt   = 0;
            model_ack = 1'b0;
        end else if (model_ack) begin
            mem_cnt   = 0;
            model_ack = 1'b0;
        end else begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_lat) begin
                model_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                mem_cnt   = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        int   cyc;
        int   last_end;
        logic exp_fs;
        exp_t e;
        cyc = 0;
        last_end = 0;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            exp_fs = instr_valid ? (stall_in & ~flush) : 1'b1;
            check("fetch_stall", 32'(fetch_stall), 32'(exp_fs));
            if (instr_valid && (!stall_in || flush)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got %0h, expected none at %0t", instruction, $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("delivery %04h at cycle %0d (expected %04h)", instruction, cyc, e.data);
                    check("instruction", 32'(instruction), 32'(e.data));
                    if (e.gap != 0) check("delivery_gap", 32'(cyc - last_end), 32'(e.gap));
                end
                last_end = cyc;
            end
        end
    end

    // Wait for the current request (if any) to finish, then for a new one.
    task automatic wait_req(input logic [15:0] addr, input string name);
        int k;
        k = 0;
        while (mem_req && k < 40) begin @(negedge clk); #4; k++; end
        k = 0;
        while (!mem_req && k < 40) begin @(negedge clk); #4; k++; end
        check({name, "_req"}, 32'(mem_req), 32'd1);
        check({name, "_addr"}, 32'(mem_addr), 32'(addr));
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 80) begin @(negedge clk); #4; k++; end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        stall_in    = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        force_ack   = 1'b0;
        model_ack   = 1'b0;
        mem_rdata   = 16'h0000;
        mem_cnt     = 0;
        mem_lat     = 4;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) | 16'h1000;

        // Reset held with stray acks pulsing.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            force_ack = (i % 2) == 0;
            #4;
            check("reset_mem_req", 32'(mem_req), 32'd0);
        end
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_instruction", 32'(instruction), 32'h0);
        check("reset_instr_valid", 32'(instr_valid), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_fetch_stall", 32'(fetch_stall), 32'd1);

        // Straight-line fetch with N=4; 0x1002 sees 3 cycles of backpressure.
        exp_q.push_back('{16'h1000, 0});
        exp_q.push_back('{16'h1002, 9});
        exp_q.push_back('{16'h1004, 6});
        exp_q.push_back('{16'h1006, 6});
        exp_q.push_back('{16'h1008, 6});
        exp_q.push_back('{16'h100A, 6});
        exp_q.push_back('{16'h100C, 6});
        exp_q.push_back('{16'h100E, 6});
        @(negedge clk);
        force_ack = 1'b0;
        rst_n = 1'b1;
        #4;
        wait_req(16'h0000, "first");

        k = 0;
        do begin @(negedge clk); k++; end while (!(instr_valid && instruction == 16'h1002) && k < 40);
        stall_in = 1'b1;
        #4;
        check("stall_mem_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #4;
            check("stall_instr", 32'(instruction), 32'h1002);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_mem_req", 32'(mem_req), 32'd0);
        end
        @(negedge clk);
        stall_in = 1'b0;
        #4;
        wait_drain("straight");

        // Flush two cycles into the fetch of 0x0010, redirect to 0x0100.
        wait_req(16'h0010, "pre_flush");
        exp_q.push_back('{16'h1100, 0});
        @(negedge clk);
        flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0100;
        #4;
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0;
        #4;
        wait_req(16'h0100, "redirect");
        wait_drain("flush_fetch");

        // Redirect to the HLT at 0x0006, then flush it in its DELIVER cycle.
        mem[16'h0006] = 16'hF123;
        wait_req(16'h0102, "pre_hlt");
        exp_q.push_back('{16'hF123, 0});
        @(negedge clk);
        flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0006;
        #4;
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!instr_valid && k < 40);
        exp_q.push_back('{16'h1020, 0});
        flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0020;
        #4;
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0;
        #4;
        check("hlt_flushed_halted", 32'(halted), 32'd0);
        wait_req(16'h0020, "resume");
        wait_drain("hlt_flush");
        check("resume_halted", 32'(halted), 32'd0);

        // Reset in the middle of the fetch of 0x0022.
        wait_req(16'h0022, "pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #4;
        @(negedge clk);
        #4;
        check("midreset_mem_req", 32'(mem_req), 32'd0);
        check("midreset_valid", 32'(instr_valid), 32'd0);
        check("midreset_addr", 32'(mem_addr), 32'h0);
        check("midreset_halted", 32'(halted), 32'd0);

        // Restart at 0x0000 and run into the HLT at 0x0006.
        exp_q.push_back('{16'h1000, 0});
        exp_q.push_back('{16'h1002, 6});
        exp_q.push_back('{16'h1004, 6});
        exp_q.push_back('{16'hF123, 6});
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        wait_req(16'h0000, "restart");
        k = 0;
        while (!halted && k < 60) begin @(negedge clk); #4; k++; end
        check("halted", 32'(halted), 32'd1);
        check("halt_drain", 32'(exp_q.size()), 32'd0);

        // Frozen while pc, flush and stray acks toggle.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            flush       = 1'($urandom_range(0, 1));
            pc_load     = 1'($urandom_range(0, 1));
            pc_load_val = 16'($urandom);
            force_ack   = 1'($urandom_range(0, 1));
            #4;
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_mem_req", 32'(mem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
        end
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0; force_ack = 1'b0;
        rst_n = 1'b0;
        #4;
        @(negedge clk);
        #4;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_fetch_stall", 32'(fetch_stall), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
